// File: rtl/vc_input_buffer_pkg.sv
`default_nettype none
// ============================================================================
// vc_input_buffer_pkg : shared sizing defaults and types for the VC buffer
// Revision: 1.0
// ============================================================================
package vc_input_buffer_pkg;

  localparam int DATA_W_DEF    = 5;
  localparam int DEPTH_DEF     = 8;
  localparam int ADDR_W_DEF    = 3;
  localparam int AF_THRESH_DEF = 6;
  localparam int AE_THRESH_DEF = 2;

  typedef enum logic {
    VC0 = 1'b0,
    VC1 = 1'b1
  } vc_id_e;

  typedef struct packed {
    logic underflow;
    logic overflow;
  } fifo_err_t;

endpackage
`default_nettype wire

// File: rtl/vc_fifo.sv
`default_nettype none
// ============================================================================
// vc_fifo : single virtual-channel circular buffer, registered 1-cycle read port
// Revision: 1.0
// ============================================================================
module vc_fifo
  import vc_input_buffer_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int AF_THRESH = AF_THRESH_DEF,
  parameter int AE_THRESH = AE_THRESH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output fifo_err_t         err
);

  localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_LVL   = (ADDR_W+1)'(AF_THRESH);
  localparam logic [ADDR_W:0] AE_LVL   = (ADDR_W+1)'(AE_THRESH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              pop_ok;
  logic              push_ok;

  always_comb begin
    empty        = (count == '0);
    full         = (count == FULL_LVL);
    almost_full  = (count >= AF_LVL);
    almost_empty = (count <= AE_LVL);
    pop_ok       = pop && !empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    push_ok      = push && (!full || pop_ok);
    err.overflow  = push && !push_ok;
    err.underflow = pop && !pop_ok;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= pop_ok;
      if (pop_ok) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + 1'b1;
      end
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !reset) begin
      mem[wr_ptr] <= data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/vc_input_buffer.sv
`default_nettype none
// ============================================================================
// vc_input_buffer : per-port ingress buffer, two VC FIFOs, pause and sticky errors
// Revision: 1.0
// ============================================================================
module vc_input_buffer
  import vc_input_buffer_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int AF_THRESH = AF_THRESH_DEF,
  parameter int AE_THRESH = AE_THRESH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] dataIn,
  input  logic              vcSel,
  input  logic              pushIn,
  input  logic              popVC0,
  input  logic              popVC1,
  output logic [DATA_W-1:0] VC0_out,
  output logic [DATA_W-1:0] VC1_out,
  output logic [1:0]        validBits,
  output logic              emptyVC0,
  output logic              emptyVC1,
  output logic [1:0]        almostFull,
  output logic [1:0]        almostEmpty,
  output logic              pause,
  output logic [1:0]        errFlags
);

  logic      push_vc0;
  logic      push_vc1;
  fifo_err_t err0;
  fifo_err_t err1;

  assign push_vc0 = pushIn && (vc_id_e'(vcSel) == VC0);
  assign push_vc1 = pushIn && (vc_id_e'(vcSel) == VC1);

  vc_fifo #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
    .AF_THRESH(AF_THRESH), .AE_THRESH(AE_THRESH)
  ) u_vc0 (
    .clk(clk), .reset(reset), .push(push_vc0), .pop(popVC0), .data(dataIn),
    .rd_data(VC0_out), .rd_valid(validBits[0]), .empty(emptyVC0),
    .almost_full(almostFull[0]), .almost_empty(almostEmpty[0]), .err(err0)
  );

  vc_fifo #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
    .AF_THRESH(AF_THRESH), .AE_THRESH(AE_THRESH)
  ) u_vc1 (
    .clk(clk), .reset(reset), .push(push_vc1), .pop(popVC1), .data(dataIn),
    .rd_data(VC1_out), .rd_valid(validBits[1]), .empty(emptyVC1),
    .almost_full(almostFull[1]), .almost_empty(almostEmpty[1]), .err(err1)
  );

  // pause trails almostFull by one cycle; upstream has DEPTH-AF_THRESH slots of slack.
  always_ff @(posedge clk) begin
    if (reset) begin
      pause    <= 1'b0;
      errFlags <= 2'b00;
    end else begin
      pause    <= |almostFull;
      errFlags <= errFlags | {err0.underflow | err1.underflow,
                              err0.overflow  | err1.overflow};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vc_input_buffer.sv
`default_nettype none
// ============================================================================
// tb_vc_input_buffer : queue-based reference model, per-cycle compare, directed pins
// Revision: 1.0
// ============================================================================
module tb_vc_input_buffer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] dataIn = '0;
  logic       vcSel = 1'b0;
  logic       pushIn = 1'b0;
  logic       popVC0 = 1'b0;
  logic       popVC1 = 1'b0;
  logic [4:0] VC0_out, VC1_out;
  logic [1:0] validBits, almostFull, almostEmpty, errFlags;
  logic       emptyVC0, emptyVC1, pause;

  int compared = 0;
  int mismatched = 0;

  vc_input_buffer dut (
    .clk(clk), .reset(reset), .dataIn(dataIn), .vcSel(vcSel), .pushIn(pushIn),
    .popVC0(popVC0), .popVC1(popVC1), .VC0_out(VC0_out), .VC1_out(VC1_out),
    .validBits(validBits), .emptyVC0(emptyVC0), .emptyVC1(emptyVC1),
    .almostFull(almostFull), .almostEmpty(almostEmpty), .pause(pause),
    .errFlags(errFlags)
  );

  always #5 clk = ~clk;

  // Reference model: one queue per VC, updated from the inputs present at each edge.
  logic [4:0] mq [2][$];
  logic [4:0] m_out [2];
  logic [1:0] m_valid = '0;
  logic [1:0] m_err = '0;
  logic       m_pause = 1'b0;
  logic       m_live = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      mq[0].delete();
      mq[1].delete();
      m_out[0] = '0;
      m_out[1] = '0;
      m_valid  = '0;
      m_err    = '0;
      m_pause  = 1'b0;
      m_live   = 1'b1;
    end else begin
      m_pause = (mq[0].size() >= 6) || (mq[1].size() >= 6);
      for (int v = 0; v < 2; v++) begin
        logic pop_r, push_r, pop_ok, push_ok;
        pop_r   = (v == 0) ? popVC0 : popVC1;
        push_r  = pushIn && (vcSel == v[0]);
        pop_ok  = pop_r && (mq[v].size() > 0);
        push_ok = push_r && ((mq[v].size() < 8) || pop_ok);
        if (pop_ok) begin
          m_out[v]   = mq[v].pop_front();
          m_valid[v] = 1'b1;
        end else begin
          m_valid[v] = 1'b0;
        end
        if (push_ok) mq[v].push_back(dataIn);
        if (push_r && !push_ok) m_err[0] = 1'b1;
        if (pop_r && !pop_ok) m_err[1] = 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_live) begin
      chk("VC0_out", 32'(VC0_out), 32'(m_out[0]));
      chk("VC1_out", 32'(VC1_out), 32'(m_out[1]));
      chk("validBits", 32'(validBits), 32'(m_valid));
      chk("emptyVC0", 32'(emptyVC0), 32'(mq[0].size() == 0));
      chk("emptyVC1", 32'(emptyVC1), 32'(mq[1].size() == 0));
      chk("almostFull", 32'(almostFull), 32'({mq[1].size() >= 6, mq[0].size() >= 6}));
      chk("almostEmpty", 32'(almostEmpty), 32'({mq[1].size() <= 2, mq[0].size() <= 2}));
      chk("pause", 32'(pause), 32'(m_pause));
      chk("errFlags", 32'(errFlags), 32'(m_err));
    end
  end

  task automatic step(input logic r, input logic p, input logic s, input logic [4:0] d,
                      input logic p0, input logic p1);
    reset = r; pushIn = p; vcSel = s; dataIn = d; popVC0 = p0; popVC1 = p1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held two cycles while a push is offered: nothing may be stored.
    step(1, 1, 0, 5'h1F, 0, 0);
    step(1, 1, 0, 5'h1E, 0, 0);
    chk("rst emptyVC0", 32'(emptyVC0), 32'd1);
    chk("rst emptyVC1", 32'(emptyVC1), 32'd1);
    chk("rst validBits", 32'(validBits), 32'd0);
    chk("rst almostEmpty", 32'(almostEmpty), 32'd3);
    chk("rst almostFull", 32'(almostFull), 32'd0);
    chk("rst pause", 32'(pause), 32'd0);
    chk("rst errFlags", 32'(errFlags), 32'd0);
    chk("rst VC0_out", 32'(VC0_out), 32'd0);
    step(0, 0, 0, 5'h00, 0, 0);
    chk("post-rst emptyVC0", 32'(emptyVC0), 32'd1);

    // Two words through VC0, one-cycle read latency, valid pulses.
    step(0, 1, 0, 5'h0A, 0, 0);
    step(0, 1, 0, 5'h0B, 0, 0);
    step(0, 0, 0, 5'h00, 1, 0);
    chk("pop1 VC0_out", 32'(VC0_out), 32'h0A);
    chk("pop1 validBits", 32'(validBits), 32'b01);
    chk("pop1 emptyVC0", 32'(emptyVC0), 32'd0);
    step(0, 0, 0, 5'h00, 1, 0);
    chk("pop2 VC0_out", 32'(VC0_out), 32'h0B);
    chk("pop2 validBits", 32'(validBits), 32'b01);
    chk("pop2 emptyVC0", 32'(emptyVC0), 32'd1);
    step(0, 0, 0, 5'h00, 0, 0);
    chk("idle validBits", 32'(validBits), 32'd0);
    chk("idle VC0_out hold", 32'(VC0_out), 32'h0B);

    // Fill VC1: almostFull at 6, pause one cycle later, 9th push refused.
    for (int i = 0; i < 9; i++) begin
      step(0, 1, 1, 5'(5'h10 + i), 0, 0);
      if (i == 5) begin
        chk("fill6 almostFull", 32'(almostFull), 32'b10);
        chk("fill6 pause", 32'(pause), 32'd0);
      end
      if (i == 6) chk("fill7 pause", 32'(pause), 32'd1);
      if (i == 7) chk("fill8 errFlags", 32'(errFlags), 32'd0);
    end
    chk("overflow errFlags", 32'(errFlags), 32'b01);
    step(0, 1, 1, 5'h1F, 0, 1);
    chk("full pop+push VC1_out", 32'(VC1_out), 32'h10);
    chk("full pop+push validBits", 32'(validBits), 32'b10);
    chk("full pop+push errFlags", 32'(errFlags), 32'b01);
    chk("full pop+push almostFull", 32'(almostFull), 32'b10);

    // Underflow on empty VC0, then push+pop on empty (push only).
    step(0, 0, 0, 5'h00, 1, 0);
    chk("underflow errFlags", 32'(errFlags), 32'b11);
    chk("underflow valid0", 32'(validBits[0]), 32'd0);
    step(0, 1, 0, 5'h07, 1, 0);
    chk("empty push+pop emptyVC0", 32'(emptyVC0), 32'd0);
    chk("empty push+pop valid0", 32'(validBits[0]), 32'd0);

    // Randomized traffic on both VCs.
    step(1, 0, 0, 5'h00, 0, 0);
    for (int i = 0; i < 600; i++) begin
      logic p, s, p0, p1;
      p  = ($urandom_range(0, 3) != 0);
      s  = 1'($urandom_range(0, 1));
      p0 = ($urandom_range(0, 99) < ((i / 150) % 2 == 0 ? 35 : 70));
      p1 = ($urandom_range(0, 99) < ((i / 150) % 2 == 0 ? 35 : 70));
      step(0, p, s, 5'($urandom), p0, p1);
    end

    // Reset mid-burst with VC0 holding four words.
    step(1, 0, 0, 5'h00, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 5'(5'h04 + i), 0, 0);
    chk("burst4 almostEmpty", 32'(almostEmpty), 32'b10);
    chk("burst4 emptyVC0", 32'(emptyVC0), 32'd0);
    step(1, 1, 0, 5'h1C, 1, 0);
    chk("midrst emptyVC0", 32'(emptyVC0), 32'd1);
    chk("midrst validBits", 32'(validBits), 32'd0);
    chk("midrst almostEmpty", 32'(almostEmpty), 32'b11);
    step(0, 0, 0, 5'h00, 0, 0);
    step(0, 0, 0, 5'h00, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
